// File: rtl/instr_fetch_controller.sv
// instr_fetch_controller
//   Sequences a combinational-read, byte-addressed instruction memory. Holds
//   the PC, captures each returned word into a 2-entry FIFO and presents the
//   head to decode with a valid/ready handshake. Handles branch redirects
//   (with queue flush), stops at END_ADDR and faults on misaligned targets.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for i_start after reset
//   FETCH | issuing fetches, pushing into the queue
//   DRAIN | program end reached, waiting for the queue to empty
//   DONE  | program finished, o_done high until i_start
//   FAULT | misaligned redirect seen, sticky until reset
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_start                    begin fetching from RESET_PC (IDLE/DONE only)
//   o_imem_addr / i_imem_data  instruction memory address / returned word
//   i_redirect_valid/_addr     branch redirect pulse and target
//   o_instr_valid/o_instr/o_instr_pc, i_instr_ready   decode handshake
//   o_busy, o_done, o_fault    status
module instr_fetch_controller #(
  parameter int unsigned byte_W   = 4,
  parameter int unsigned Addr_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned END_ADDR = 68
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  output logic [Addr_W-1:0]     o_imem_addr,
  input  logic [8*byte_W-1:0]   i_imem_data,
  input  logic                  i_redirect_valid,
  input  logic [Addr_W-1:0]     i_redirect_addr,
  output logic                  o_instr_valid,
  output logic [8*byte_W-1:0]   o_instr,
  output logic [Addr_W-1:0]     o_instr_pc,
  input  logic                  i_instr_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault
);

  localparam int unsigned       DATA_W  = 8*byte_W;
  localparam logic [Addr_W-1:0] PC_RST  = Addr_W'(RESET_PC);
  localparam logic [Addr_W:0]   PC_END  = (Addr_W+1)'(END_ADDR);
  localparam logic [Addr_W:0]   PC_STEP = (Addr_W+1)'(byte_W);
  localparam logic [Addr_W-1:0] ALIGN   = Addr_W'(byte_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [Addr_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   qdata_q [2];
  logic [DATA_W-1:0]   qdata_d [2];
  logic [Addr_W-1:0]   qpc_q   [2];
  logic [Addr_W-1:0]   qpc_d   [2];
  logic [1:0]          cnt_q, cnt_d;

  logic [Addr_W:0]     pc_inc;
  logic [1:0]          cnt_post;
  logic                head_valid, pop, push, flush;
  logic                at_end, misaligned, redir_take;

  assign head_valid = (cnt_q != 2'd0);
  assign pop        = head_valid & i_instr_ready;
  // Full check is made against the occupancy left after this cycle's pop.
  assign cnt_post   = cnt_q - {1'b0, pop};
  // One extra bit so a wrap past the top of memory is seen as program end.
  assign pc_inc     = {1'b0, pc_q} + PC_STEP;
  assign at_end     = pc_inc[Addr_W] | (pc_inc > PC_END);
  assign misaligned = (i_redirect_addr % ALIGN) != '0;
  assign redir_take = i_redirect_valid & ((state_q == S_FETCH) | (state_q == S_DRAIN));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RST;
      cnt_q      <= 2'd0;
      qdata_q[0] <= '0;
      qdata_q[1] <= '0;
      qpc_q[0]   <= '0;
      qpc_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      qdata_q    <= qdata_d;
      qpc_q      <= qpc_d;
    end
  end

  // Next-state and fetch control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_FETCH;
          pc_d    = PC_RST;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (redir_take) begin
          // A head accepted this cycle still completes; everything else goes.
          flush = 1'b1;
          if (misaligned) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_FETCH;
            pc_d    = i_redirect_addr;
          end
        end else if (state_q == S_FETCH) begin
          if (at_end) begin
            state_d = S_DRAIN;
          end else if (cnt_post != 2'd2) begin
            push = 1'b1;
            pc_d = pc_inc[Addr_W-1:0];
          end
        end else if (!head_valid) begin
          state_d = S_DONE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch queue: pop shifts entry 1 to the head, push lands behind survivors.
  always_comb begin
    cnt_d   = cnt_post;
    qdata_d = qdata_q;
    qpc_d   = qpc_q;
    if (pop) begin
      qdata_d[0] = qdata_q[1];
      qpc_d[0]   = qpc_q[1];
    end
    if (flush) begin
      cnt_d = 2'd0;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        qdata_d[0] = i_imem_data;
        qpc_d[0]   = pc_q;
      end else begin
        qdata_d[1] = i_imem_data;
        qpc_d[1]   = pc_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  // Outputs
  always_comb begin
    o_imem_addr   = pc_q;
    o_instr_valid = head_valid;
    o_instr       = head_valid ? qdata_q[0] : '0;
    o_instr_pc    = head_valid ? qpc_q[0]   : '0;
    o_busy        = (state_q == S_FETCH) | (state_q == S_DRAIN);
    o_done        = (state_q == S_DONE);
    o_fault       = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_instr_fetch_controller.sv
// Bench for instr_fetch_controller: directed vector table, hand-written
// corner sequences and a randomized run, all checked against a queue-based
// reference model of the fetch rules.
module tb_instr_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        rv;
  logic [7:0]  ra;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        ready;
  logic        busy, done, fault;

  logic [31:0] mem [64];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  instr_fetch_controller #(
    .byte_W(4), .Addr_W(8), .RESET_PC(0), .END_ADDR(68)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (start),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_redirect_valid (rv),
    .i_redirect_addr  (ra),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .i_instr_ready    (ready),
    .o_busy           (busy),
    .o_done           (done),
    .o_fault          (fault)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_DRAIN = 2, M_DONE = 3, M_FAULT = 4;
  localparam int END_A  = 68;

  typedef struct {
    int          pc;
    logic [31:0] word;
  } ent_t;

  ent_t mq[$];
  int   m_mode = M_IDLE;
  int   m_pc   = 0;

  task automatic model_step(input bit st, input bit rdy, input bit rvv,
                            input logic [7:0] raa, input bit rs);
    bit   accept;
    bit   was_empty;
    ent_t e;
    if (rs) begin
      m_mode = M_IDLE;
      m_pc   = 0;
      mq.delete();
      return;
    end
    accept    = (mq.size() > 0) && rdy;
    was_empty = (mq.size() == 0);
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (st) begin m_mode = M_FETCH; m_pc = 0; end
      end
      M_FETCH, M_DRAIN: begin
        if (rvv) begin
          mq.delete();
          if ((int'(raa) % 4) != 0) m_mode = M_FAULT;
          else begin m_mode = M_FETCH; m_pc = int'(raa); end
        end else if (m_mode == M_FETCH) begin
          if (accept) void'(mq.pop_front());
          if (m_pc + 4 > END_A) m_mode = M_DRAIN;
          else if (mq.size() < 2) begin
            e.pc = m_pc; e.word = mem[m_pc / 4];
            mq.push_back(e);
            m_pc += 4;
          end
        end else begin
          if (accept) void'(mq.pop_front());
          if (was_empty) m_mode = M_DONE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit v;
    v = (mq.size() > 0);
    chk("m_valid", 32'(instr_valid), 32'(v));
    chk("m_instr", instr, v ? mq[0].word : 32'h0);
    chk("m_pc",    32'(instr_pc), v ? 32'(mq[0].pc) : 32'h0);
    chk("m_addr",  32'(imem_addr), 32'(m_pc));
    chk("m_busy",  32'(busy),  32'((m_mode == M_FETCH) || (m_mode == M_DRAIN)));
    chk("m_done",  32'(done),  32'(m_mode == M_DONE));
    chk("m_fault", 32'(fault), 32'(m_mode == M_FAULT));
  endtask

  // Drive one cycle's inputs, advance the model, clock, then compare.
  task automatic cycle(input bit st, input bit rdy, input bit rvv,
                       input logic [7:0] raa, input bit rs);
    start = st; ready = rdy; rv = rvv; ra = raa; reset = rs;
    model_step(st, rdy, rvv, raa, rs);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rs, st, rdy;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_busy, e_done, e_fault;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs [6];

  int last_pc, acc_cyc, done_cyc;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hE412_1000;
    mem[1] = 32'hE412_3004;
    mem[2] = 32'hE043_3001;

    start = 0; ready = 0; rv = 0; ra = 0; reset = 1;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0,          1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,          1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0,          1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 32'hE412_1000,  1'b1, 1'b0, 1'b0, 8'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 32'hE412_3004,  1'b1, 1'b0, 1'b0, 8'd8};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd8, 32'hE043_3001,  1'b1, 1'b0, 1'b0, 8'd12};

    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].st, vecs[i].rdy, 1'b0, 8'd0, vecs[i].rs);
      chk("vec_valid", 32'(instr_valid), 32'(vecs[i].e_valid));
      chk("vec_pc",    32'(instr_pc),    32'(vecs[i].e_pc));
      chk("vec_instr", instr,            vecs[i].e_instr);
      chk("vec_busy",  32'(busy),        32'(vecs[i].e_busy));
      chk("vec_done",  32'(done),        32'(vecs[i].e_done));
      chk("vec_fault", 32'(fault),       32'(vecs[i].e_fault));
      chk("vec_addr",  32'(imem_addr),   32'(vecs[i].e_addr));
    end

    // ---- backpressure: queue fills, PC parks at 8, head held at pc 0 ----
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("bp_first_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    chk("bp_head_pc", 32'(instr_pc), 32'd0);
    chk("bp_addr",    32'(imem_addr), 32'd8);
    for (int k = 0; k < 3; k++) begin
      chk("bp_rel_valid", 32'(instr_valid), 32'd1);
      chk("bp_rel_pc",    32'(instr_pc), 32'(k * 4));
      cycle(0, 1, 0, 0, 0);
    end

    // ---- run to end of program with ready high ----
    last_pc = -1; acc_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      if (instr_valid) begin last_pc = int'(instr_pc); acc_cyc = i; end
      cycle(0, 1, 0, 0, 0);
      if (done) done_cyc = i;
    end
    chk("end_reached",    32'(done), 32'd1);
    chk("end_last_pc",    32'(last_pc), 32'd64);
    chk("end_done_delay", 32'(done_cyc - acc_cyc), 32'd1);
    chk("end_busy_low",   32'(busy), 32'd0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("restart_valid", 32'(instr_valid), 32'd1);
    chk("restart_pc",    32'(instr_pc), 32'd0);

    // ---- redirect while queue holds pcs 12 and 16 ----
    cycle(0, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && instr_pc == 8'd12) break;
      cycle(0, 1, 0, 0, 0);
    end
    chk("rd_head12", 32'(instr_pc), 32'd12);
    cycle(0, 0, 0, 0, 0);
    chk("rd_held12", 32'(instr_pc), 32'd12);
    chk("rd_addr20", 32'(imem_addr), 32'd20);
    cycle(0, 1, 1, 8'd44, 0);
    chk("rd_flush_valid", 32'(instr_valid), 32'd0);
    chk("rd_addr44",      32'(imem_addr), 32'd44);
    cycle(0, 1, 0, 0, 0);
    chk("rd_valid44", 32'(instr_valid), 32'd1);
    chk("rd_pc44",    32'(instr_pc), 32'd44);
    chk("rd_instr44", instr, mem[11]);

    // ---- misaligned redirect -> sticky fault ----
    cycle(0, 1, 1, 8'd45, 0);
    chk("flt_fault", 32'(fault), 32'd1);
    chk("flt_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 1, 8'd8, 0);
      chk("flt_sticky", 32'(fault), 32'd1);
    end
    cycle(0, 1, 0, 0, 1);
    chk("flt_cleared", 32'(fault), 32'd0);

    // ---- reset mid-fetch at pc 20 ----
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (imem_addr == 8'd20) break;
      cycle(0, 1, 0, 0, 0);
    end
    chk("rst_at20", 32'(imem_addr), 32'd20);
    cycle(0, 1, 1, 8'd40, 1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    32'(instr_pc), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("rst_refetch_valid", 32'(instr_valid), 32'd1);
    chk("rst_refetch_pc",    32'(instr_pc), 32'd0);

    // ---- randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      bit         st, rdy, rvv, rs;
      logic [7:0] raa;
      int         sel;
      st  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rvv = ($urandom_range(0, 11) == 0);
      rs  = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      raa = 8'($urandom_range(0, 255));
      else if (sel < 3)  raa = 8'($urandom_range(17, 63) * 4);
      else               raa = 8'($urandom_range(0, 16) * 4);
      cycle(st, rdy, rvv, raa, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
